// File: rtl/bandai_mapper_gen2.sv
// Cartridge mapper: address-key unlock, serial auth bitstream on SO, bank registers and relock.
// Define MAPPER_GPIO_EN to add the IOCTL/IOSCN GPIO registers at 0xCC/0xCD.
module bandai_mapper_gen2 #(
  parameter int                      NUM_ROM_BANKS = 2,
  parameter int                      BANK_W        = 8,
  parameter int                      RADDR_W       = 7,
  parameter int                      UNLOCK_LEN    = 2,
  parameter logic [8*UNLOCK_LEN-1:0] UNLOCK_KEY    = 16'hA55A,
  parameter int                      SO_LEN        = 18,
  parameter logic [SO_LEN-1:0]       SO_PATTERN    = 18'h05140,
  parameter logic [7:0]              RELOCK_VAL    = 8'hA5
`ifdef MAPPER_GPIO_EN
  ,
  parameter int                      IO_W          = 4
`endif
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               CEn,
  input  logic               SSn,
  input  logic               OEn,
  input  logic               WEn,
  input  logic [7:0]         ADDR,
  input  logic [7:0]         DQ_I,
  output logic [7:0]         DQ_O,
  output logic               DQ_OE,
  output logic               SO,
  output logic               SO_OE,
  output logic               ROMCEn,
  output logic               RAMCEn,
  output logic [RADDR_W-1:0] RADDR
`ifdef MAPPER_GPIO_EN
  ,
  input  logic [IO_W-1:0]    IO_I,
  output logic [IO_W-1:0]    IO_O,
  output logic [IO_W-1:0]    IO_OE
`endif
);

  localparam int         CNT_W  = $clog2(SO_LEN + 1);
  localparam logic [7:0] A_LAO  = 8'hC0;
  localparam logic [7:0] A_RAM  = 8'hC1;
  localparam logic [7:0] A_ROM0 = 8'hC2;
  localparam logic [7:0] A_STAT = 8'hCF;

  typedef enum logic [1:0] {
    ST_LOCKED,
    ST_STREAM,
    ST_OPEN
  } state_t;

  state_t                          state_q, state_d;
  logic [3:0]                      step_q, step_d;
  logic [SO_LEN-1:0]               sr_q, sr_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            wr_pend_q, wr_pend_d;
  logic [7:0]                      wr_addr_q, wr_addr_d;
  logic [7:0]                      wr_data_q, wr_data_d;
  logic [BANK_W-1:0]               lao_q, lao_d;
  logic [BANK_W-1:0]               ram_bank_q, ram_bank_d;
  logic [NUM_ROM_BANKS*BANK_W-1:0] rom_banks;

  logic              unlocked, streaming, sel, cap, commit, relock;
  logic [BANK_W-1:0] wr_bank;
  logic [7:0]        cur_key, status, rd_val;
  logic              rd_hit, rce, ram_sel, rom_sel;
  logic [3:0]        seg;
  logic [RADDR_W-1:0] raddr_v;

  assign unlocked  = (state_q != ST_LOCKED);
  assign streaming = (state_q == ST_STREAM);
  assign sel       = ~SSn | ~CEn;
  assign status    = {unlocked, streaming, 2'b00, step_q};
  assign wr_bank   = BANK_W'(wr_data_q);

  // Each low-WEn cycle overwrites the capture; the first high-WEn cycle commits it once.
  assign cap    = unlocked & sel & ~WEn;
  assign commit = wr_pend_q & WEn;
  assign relock = commit & (wr_addr_q == A_STAT) & (wr_data_q == RELOCK_VAL);

  always_comb begin
    wr_pend_d = wr_pend_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (cap) begin
      wr_pend_d = 1'b1;
      wr_addr_d = ADDR;
      wr_data_d = DQ_I;
    end else if (commit) begin
      wr_pend_d = 1'b0;
    end
  end

  always_comb begin
    lao_d      = lao_q;
    ram_bank_d = ram_bank_q;
    if (commit && (wr_addr_q == A_LAO)) lao_d = wr_bank;
    if (commit && (wr_addr_q == A_RAM)) ram_bank_d = wr_bank;
  end

  for (genvar gi = 0; gi < NUM_ROM_BANKS; gi++) begin : g_rom_bank
    logic [BANK_W-1:0] bank_q, bank_d;

    always_comb begin
      bank_d = bank_q;
      if (commit && (wr_addr_q == 8'(A_ROM0 + gi))) bank_d = wr_bank;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) bank_q <= '1;
      else       bank_q <= bank_d;
    end

    assign rom_banks[gi*BANK_W +: BANK_W] = bank_q;
  end

  always_comb begin
    cur_key = UNLOCK_KEY[7:0];
    for (int i = 0; i < UNLOCK_LEN; i++) begin
      if (step_q == 4'(i)) cur_key = UNLOCK_KEY[8*i +: 8];
    end
  end

  // Relock has priority over any key progress or stream activity on the same edge.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    if (relock) begin
      state_d = ST_LOCKED;
      step_d  = 4'd0;
      sr_d    = '1;
    end else begin
      case (state_q)
        ST_LOCKED: begin
          if (ADDR == cur_key) begin
            if (step_q == 4'(UNLOCK_LEN - 1)) begin
              state_d = ST_STREAM;
              step_d  = 4'd0;
              sr_d    = SO_PATTERN;
              cnt_d   = CNT_W'(SO_LEN);
            end else begin
              step_d = step_q + 4'd1;
            end
          end
        end
        ST_STREAM: begin
          sr_d  = SO_LEN'({1'b1, sr_q} >> 1);
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_OPEN;
        end
        ST_OPEN: begin
        end
        default: state_d = ST_LOCKED;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_LOCKED;
      step_q     <= 4'd0;
      sr_q       <= '1;
      cnt_q      <= '0;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      lao_q      <= '1;
      ram_bank_q <= '1;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      lao_q      <= lao_d;
      ram_bank_q <= ram_bank_d;
    end
  end

`ifdef MAPPER_GPIO_EN
  logic [IO_W-1:0] ioctl_q, ioctl_d;
  logic [IO_W-1:0] ioscn_q, ioscn_d;

  always_comb begin
    ioctl_d = ioctl_q;
    ioscn_d = ioscn_q;
    if (commit && (wr_addr_q == 8'hCC)) ioctl_d = IO_W'(wr_data_q);
    if (commit && (wr_addr_q == 8'hCD)) ioscn_d = IO_W'(wr_data_q);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ioctl_q <= '0;
      ioscn_q <= '0;
    end else begin
      ioctl_q <= ioctl_d;
      ioscn_q <= ioscn_d;
    end
  end

  assign IO_OE = ioctl_q;
  assign IO_O  = ioscn_q;
`endif

  always_comb begin
    rd_hit = 1'b0;
    rd_val = 8'h00;
    if (ADDR == A_LAO) begin
      rd_hit = 1'b1;
      rd_val = 8'(lao_q);
    end
    if (ADDR == A_RAM) begin
      rd_hit = 1'b1;
      rd_val = 8'(ram_bank_q);
    end
    for (int i = 0; i < NUM_ROM_BANKS; i++) begin
      if (ADDR == 8'(A_ROM0 + i)) begin
        rd_hit = 1'b1;
        rd_val = 8'(rom_banks[i*BANK_W +: BANK_W]);
      end
    end
    if (ADDR == A_STAT) begin
      rd_hit = 1'b1;
      rd_val = status;
    end
`ifdef MAPPER_GPIO_EN
    if (ADDR == 8'hCC) begin
      rd_hit = 1'b1;
      rd_val = 8'(ioctl_q);
    end
    if (ADDR == 8'hCD) begin
      // Output-enabled pins read back their driven value, the rest read the pad.
      rd_hit = 1'b1;
      rd_val = 8'((ioctl_q & ioscn_q) | (~ioctl_q & IO_I));
    end
`endif
  end

  assign DQ_OE = unlocked & sel & ~OEn & WEn & rd_hit;
  assign DQ_O  = DQ_OE ? rd_val : 8'h00;

  assign seg     = ADDR[7:4];
  assign rce     = unlocked & SSn & ~CEn;
  assign ram_sel = rce & (seg == 4'd1);
  assign rom_sel = rce & (seg >= 4'd2);

  // Segments beyond the direct ROM banks form their address from LAO plus the segment.
  always_comb begin
    raddr_v = '0;
    if (ram_sel) begin
      raddr_v = RADDR_W'(ram_bank_q);
    end else if (rom_sel) begin
      raddr_v = RADDR_W'({lao_q[RADDR_W-5:0], seg});
      for (int i = 0; i < NUM_ROM_BANKS; i++) begin
        if (seg == 4'(2 + i)) raddr_v = RADDR_W'(rom_banks[i*BANK_W +: BANK_W]);
      end
    end
  end

  assign RADDR  = raddr_v;
  assign RAMCEn = ~ram_sel;
  assign ROMCEn = ~rom_sel;
  assign SO     = streaming ? sr_q[0] : 1'b1;
  assign SO_OE  = RSTn;

endmodule
